// File: rtl/repetition_serial_encoder.sv
// Repetition serial encoder: holds one accepted word and presents it REPETITION
// times downstream with a copy index, streaming back-to-back words without bubbles.
module repetition_serial_encoder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REPETITION = 3,
    localparam int unsigned INDEX_WIDTH = (REPETITION > 1) ? $clog2(REPETITION) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   write_valid,
    input  logic [DATA_WIDTH-1:0]  write_data,
    output logic                   write_ready,
    output logic                   read_valid,
    output logic [DATA_WIDTH-1:0]  read_data,
    output logic [INDEX_WIDTH-1:0] read_index,
    output logic                   read_last,
    input  logic                   read_ready,
    output logic                   busy
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REPETITION - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [INDEX_WIDTH-1:0] index_q;

    assign read_valid  = (state_q == StSend);
    assign read_data   = data_q;
    assign read_index  = index_q;
    assign read_last   = (index_q == LAST_INDEX);
    assign busy        = read_valid;
    // The last copy leaving frees the holding register in the same cycle.
    assign write_ready = !read_valid || (read_ready && read_last);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            data_q  <= '0;
            index_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (write_valid) begin
                        state_q <= StSend;
                        data_q  <= write_data;
                        index_q <= '0;
                    end
                end
                StSend: begin
                    if (read_ready) begin
                        if (read_last) begin
                            index_q <= '0;
                            if (write_valid) begin
                                data_q <= write_data;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            index_q <= index_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    index_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repetition_serial_encoder.sv
// Bench for repetition_serial_encoder: directed vector table and reset sequence on a
// REPETITION=3 build, plus randomized scoreboard runs on REPETITION=1 and 5 builds.
module tb_repetition_serial_encoder;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    bit random_go = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed DUT, REPETITION = 3
    logic       wv, rr, wr, rv, last, busy;
    logic [7:0] wd, rd;
    logic [1:0] idx;

    repetition_serial_encoder #(.DATA_WIDTH(8), .REPETITION(3)) u_dut3 (
        .clock       (clock),
        .resetn      (resetn),
        .write_valid (wv),
        .write_data  (wd),
        .write_ready (wr),
        .read_valid  (rv),
        .read_data   (rd),
        .read_index  (idx),
        .read_last   (last),
        .read_ready  (rr),
        .busy        (busy)
    );

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       rv;
        logic [7:0] rd;
        logic [1:0] idx;
        logic       last;
        logic       wr;
    } vec_t;

    // Randomized builds: REPETITION 1 and 5, each checked against a word-level scoreboard.
    for (genvar g = 0; g < 2; g++) begin : gen_rand
        localparam int unsigned R  = (g == 0) ? 1 : 5;
        localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

        logic          r_wv = 1'b0, r_rr = 1'b0;
        logic [7:0]    r_wd = '0;
        logic          r_wr, r_rv, r_last, r_busy;
        logic [7:0]    r_rd;
        logic [IW-1:0] r_idx;
        bit            done = 1'b0;

        repetition_serial_encoder #(.DATA_WIDTH(8), .REPETITION(R)) u_dut (
            .clock       (clock),
            .resetn      (resetn),
            .write_valid (r_wv),
            .write_data  (r_wd),
            .write_ready (r_wr),
            .read_valid  (r_rv),
            .read_data   (r_rd),
            .read_index  (r_idx),
            .read_last   (r_last),
            .read_ready  (r_rr),
            .busy        (r_busy)
        );

        initial begin
            bit         held;
            logic [7:0] word;
            int         cnt;
            int         words;
            logic [7:0] copies[$];
            logic       exp_wr;
            logic [7:0] corrected;
            logic       err;
            int         ones;
            string      tag;

            held  = 1'b0;
            word  = '0;
            cnt   = 0;
            words = 0;
            tag   = $sformatf("R%0d", R);
            wait (random_go);
            for (int cyc = 0; cyc < 800; cyc++) begin
                @(posedge clock);
                #1;
                chk({tag, " read_valid"}, 32'(r_rv), 32'(held));
                chk({tag, " busy"}, 32'(r_busy), 32'(held));
                if (held) begin
                    chk({tag, " read_data"}, 32'(r_rd), 32'(word));
                    chk({tag, " read_index"}, 32'(r_idx), 32'(cnt));
                    chk({tag, " read_last"}, 32'(r_last), 32'(cnt == int'(R) - 1));
                end
                r_wv = ($urandom_range(0, 3) != 0);
                r_wd = 8'($urandom);
                r_rr = ($urandom_range(0, 3) != 0);
                #1;
                exp_wr = !held || (r_rr && (cnt == int'(R) - 1));
                chk({tag, " write_ready"}, 32'(r_wr), 32'(exp_wr));
                if (held && r_rr) begin
                    copies.push_back(r_rd);
                    cnt++;
                    if (cnt == int'(R)) begin
                        // Corrector: majority vote per bit, error if any code copy differs.
                        err = 1'b0;
                        for (int k = 1; k < copies.size(); k++)
                            if (copies[k] != copies[0]) err = 1'b1;
                        for (int b = 0; b < 8; b++) begin
                            ones = 0;
                            for (int k = 0; k < copies.size(); k++) ones += int'(copies[k][b]);
                            corrected[b] = (2 * ones > copies.size());
                        end
                        chk({tag, " copy count"}, 32'(copies.size()), R);
                        chk({tag, " corrector error"}, 32'(err), 32'd0);
                        chk({tag, " corrected data"}, 32'(corrected), 32'(word));
                        copies.delete();
                        held = 1'b0;
                        words++;
                    end
                end
                if (r_wv && exp_wr) begin
                    held = 1'b1;
                    word = r_wd;
                    cnt  = 0;
                    copies.delete();
                end
            end
            chk({tag, " words completed"}, 32'(words > 20), 32'd1);
            r_wv = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        vec_t tbl[$];

        wv = 1'b0; wd = '0; rr = 1'b0;

        // Single word 0xA5
        tbl.push_back('{1, 8'hA5, 1, 0, 8'h00, 0, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 8'hA5, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'hA5, 1, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'hA5, 2, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
        // Back-to-back 0x11, 0x22
        tbl.push_back('{1, 8'h11, 1, 0, 8'h00, 0, 0, 1});
        tbl.push_back('{1, 8'h22, 1, 1, 8'h11, 0, 0, 0});
        tbl.push_back('{1, 8'h22, 1, 1, 8'h11, 1, 0, 0});
        tbl.push_back('{1, 8'h22, 1, 1, 8'h11, 2, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h22, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h22, 1, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h22, 2, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
        // 0x3C stalled for 4 cycles on its first copy
        tbl.push_back('{1, 8'h3C, 1, 0, 8'h00, 0, 0, 1});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h3C, 0, 0, 0});
        tbl.push_back('{1, 8'h77, 0, 1, 8'h3C, 0, 0, 0});
        tbl.push_back('{1, 8'h77, 0, 1, 8'h3C, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h3C, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h3C, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h3C, 1, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h3C, 2, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 0, 1});

        repeat (2) @(posedge clock);
        #1;
        chk("reset read_valid", 32'(rv), 32'd0);
        chk("reset read_index", 32'(idx), 32'd0);
        chk("reset read_data", 32'(rd), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clock);
            #1;
            wv = tbl[i].wv;
            wd = tbl[i].wd;
            rr = tbl[i].rr;
            #1;
            chk($sformatf("vec%0d read_valid", i), 32'(rv), 32'(tbl[i].rv));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].rv));
            chk($sformatf("vec%0d write_ready", i), 32'(wr), 32'(tbl[i].wr));
            chk($sformatf("vec%0d read_index", i), 32'(idx), 32'(tbl[i].idx));
            if (tbl[i].rv) begin
                chk($sformatf("vec%0d read_data", i), 32'(rd), 32'(tbl[i].rd));
                chk($sformatf("vec%0d read_last", i), 32'(last), 32'(tbl[i].last));
            end
        end

        // Reset pulse while copy index 1 of 0xFF is presented
        @(posedge clock);
        #1;
        wv = 1'b1; wd = 8'hFF; rr = 1'b1;
        #1;
        chk("ff write_ready", 32'(wr), 32'd1);
        @(posedge clock);
        #1;
        wv = 1'b0;
        #1;
        chk("ff copy0 data", 32'(rd), 32'hFF);
        chk("ff copy0 index", 32'(idx), 32'd0);
        @(posedge clock);
        #1;
        chk("ff copy1 index", 32'(idx), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid reset read_valid", 32'(rv), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset read_index", 32'(idx), 32'd0);
        chk("mid reset read_data", 32'(rd), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("post reset %0d read_valid", i), 32'(rv), 32'd0);
            chk($sformatf("post reset %0d write_ready", i), 32'(wr), 32'd1);
        end

        random_go = 1'b1;
        for (int c = 0; c < 5000 && !(gen_rand[0].done && gen_rand[1].done); c++)
            @(posedge clock);
        chk("random R1 finished", 32'(gen_rand[0].done), 32'd1);
        chk("random R5 finished", 32'(gen_rand[1].done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/repetition_serial_encoder.md
REPETITION_SERIAL_ENCODER -- requirements
Module: repetition_serial_encoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one data word.
REQ-002 Parameter REPETITION, default 3, number of copies transmitted per word; legal range 1 or more.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 write_valid  input  1  upstream offers a word.
REQ-006 write_data  input  DATA_WIDTH  word to encode.
REQ-007 write_ready  output  1  encoder accepts the word this cycle.
REQ-008 read_valid  output  1  one copy is presented downstream.
REQ-009 read_data  output  DATA_WIDTH  current copy of the accepted word.
REQ-010 read_index  output  max(1,$clog2(REPETITION))  copy number, 0 to REPETITION-1.
REQ-011 read_last  output  1  high when read_index equals REPETITION-1.
REQ-012 read_ready  input  1  downstream accepts the presented copy.
REQ-013 busy  output  1  a word is held and not all copies are transferred.

Function
REQ-014 Two states: IDLE (no word held) and SEND (word held, copies pending).
REQ-015 write_ready SHALL be high in IDLE, or in SEND when read_valid, read_ready and read_last are all high; it is combinational and never depends on write_valid.
REQ-016 The input handshake occurs when write_valid and write_ready are both high; write_data is registered and the state becomes SEND with read_index 0.
REQ-017 read_valid SHALL be high exactly in SEND; read_data SHALL equal the registered word for every copy.
REQ-018 The output handshake occurs when read_valid and read_ready are both high; read_index then increments by 1.
REQ-019 On the output handshake with read_last high, the encoder returns to IDLE, or stays in SEND with read_index 0 and the new word when an input handshake occurs in the same cycle.
REQ-020 Back-to-back words SHALL stream with no bubble: sustained throughput of one copy per cycle with read_ready held high.
REQ-021 Latency: the first copy of a word is presented the cycle after its input handshake; REPETITION output handshakes per word.
REQ-022 With read_ready low, read_valid, read_data, read_index and read_last SHALL hold stable.
REQ-023 With REPETITION equal to 1, read_index is constantly 0 and read_last is constantly high while read_valid is high.
REQ-024 read_index SHALL never exceed REPETITION-1, including when REPETITION is not a power of two.
REQ-025 busy SHALL equal read_valid.
REQ-026 The copy sequence of a word, concatenated with the first copy as data and the remaining copies in index order as code, SHALL be accepted by the team's repetition corrector with error low.

Reset
REQ-027 While resetn is low: state IDLE, read_valid 0, read_index 0, read_data 0, busy 0, and write_ready 1 from the first cycle after release.
REQ-028 Reset asserted mid-word SHALL discard the held word and its remaining copies without any further output handshake.

Structure
REQ-029 No shared-package entries are needed: the state encoding and the index width localparam stay local to the module.
REQ-030 There is no sub-module; the block is a single module of registers, counter and handshake logic.

Verification
REQ-031 DATA_WIDTH 8, REPETITION 3, read_ready high, write 0xA5 once -> read_data 0xA5 on 3 consecutive cycles, read_index 0,1,2, read_last only on index 2, then read_valid low.
REQ-032 Words 0x11, 0x22 offered back-to-back with read_ready high -> 6 contiguous copies (0x11 x3 then 0x22 x3), and write_ready high on the last copy of 0x11.
REQ-033 read_ready low for 4 cycles after the first copy of 0x3C -> outputs held stable and write_ready low; on release, the remaining copies at index 1 and 2 follow.
REQ-034 resetn pulsed low during index 1 of 0xFF -> read_valid 0 immediately, no further copies of 0xFF, and write_ready high after release.
REQ-035 REPETITION 1 and REPETITION 5 builds, random data and random read_ready -> copy count per word is exactly REPETITION, and the reassembled block gives corrector error 0 with corrected data equal to the input word.
